// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS-compatible core.
// It sequences FETCH/DECODE/EXEC1/EXEC2 and stalls on memory waitrequest.
// Three conditions stop the core in HALTED, which only reset leaves:
//   - an illegal instruction,
//   - jr to address zero,
//   - an optional memory-stall timeout.
// All datapath strobes are combinational functions of the registered
// state and the current opcode/fncode (plus alu_zero for branches).
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int TIMEOUT_W       = 8,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] fncode,
  input  logic       waitrequest,
  input  logic       alu_zero,
  input  logic       jr_target_zero,
  output logic [2:0] state,
  output logic [1:0] regdst,
  output logic       regwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsource,
  output logic       memread,
  output logic       memwrite,
  output logic [1:0] memtoreg,
  output logic [1:0] aluop,
  output logic       alusrc,
  output logic       active,
  output logic       illegal,
  output logic       timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC1  = 3'd3;
  localparam logic [2:0] S_EXEC2  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  // A zero TIMEOUT_CYCLES turns the stall watchdog off entirely.
  localparam bit                   TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic is_rtype, is_alu, is_jr, is_addiu, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_jal;
  logic mem_wait, to_hit;

  // Instruction class decode; anything not matched is treated as illegal.
  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_alu   = is_rtype && ((fncode == FN_ADDU) || (fncode == FN_SUBU) ||
                            (fncode == FN_AND)  || (fncode == FN_OR));
    is_jr    = is_rtype && (fncode == FN_JR);
    is_addiu = (opcode == OP_ADDIU);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
  end

  // A memory state is being held open by waitrequest this cycle.
  // The timeout fires on the last permitted stall cycle.
  always_comb begin
    mem_wait = waitrequest && ((state_q == S_FETCH) ||
                               ((state_q == S_EXEC1) && is_lw) ||
                               ((state_q == S_EXEC2) && is_sw));
    to_hit   = TO_EN && mem_wait && (cnt_q == TO_LAST);
  end

  // Datapath strobes for the current state.
  always_comb begin
    regdst   = 2'd0;
    regwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsource = 2'd0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 2'd0;
    aluop    = 2'd0;
    alusrc   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        iord    = 1'b0;
      end
      S_DECODE: begin
        // Latch the instruction and step PC to PC+4 in one go.
        irwrite  = 1'b1;
        pcwrite  = 1'b1;
        pcsource = 2'd0;
        aluop    = 2'd0;
      end
      S_EXEC1: begin
        if (is_alu) begin
          aluop  = 2'd2;
          alusrc = 1'b0;
        end else if (is_jr) begin
          pcwrite  = 1'b1;
          pcsource = 2'd3;
        end else if (is_addiu || is_sw) begin
          aluop  = 2'd0;
          alusrc = 1'b1;
        end else if (is_lw) begin
          aluop   = 2'd0;
          alusrc  = 1'b1;
          iord    = 1'b1;
          memread = 1'b1;
        end else if (is_beq || is_bne) begin
          aluop    = 2'd1;
          alusrc   = 1'b0;
          pcsource = 2'd1;
          pcwrite  = is_beq ? alu_zero : !alu_zero;
        end else if (is_j) begin
          pcwrite  = 1'b1;
          pcsource = 2'd2;
        end else if (is_jal) begin
          // PC still holds PC+4 here, so the link write sees the return address.
          pcwrite  = 1'b1;
          pcsource = 2'd2;
          regwrite = 1'b1;
          regdst   = 2'd2;
          memtoreg = 2'd2;
        end
      end
      S_EXEC2: begin
        if (is_alu) begin
          regwrite = 1'b1;
          regdst   = 2'd1;
          memtoreg = 2'd0;
        end else if (is_addiu) begin
          regwrite = 1'b1;
          regdst   = 2'd0;
          memtoreg = 2'd0;
        end else if (is_lw) begin
          regwrite = 1'b1;
          regdst   = 2'd0;
          memtoreg = 2'd1;
        end else if (is_sw) begin
          iord     = 1'b1;
          memwrite = 1'b1;
          aluop    = 2'd0;
          alusrc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next state and sticky halt-cause flags.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (!waitrequest) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1: begin
        if (is_alu || is_addiu || is_sw) begin
          state_d = S_EXEC2;
        end else if (is_lw) begin
          if (!waitrequest) state_d = S_EXEC2;
        end else if (is_jr) begin
          state_d = jr_target_zero ? S_HALTED : S_FETCH;
        end else if (is_beq || is_bne || is_j || is_jal) begin
          state_d = S_FETCH;
        end else if (HALT_ON_ILLEGAL != 0) begin
          state_d   = S_HALTED;
          illegal_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC2:  if (!(is_sw && waitrequest)) state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      // Unused encodings park the core rather than run off.
      default:  state_d = S_HALTED;
    endcase
    if (to_hit) begin
      state_d   = S_HALTED;
      timeout_d = 1'b1;
    end
  end

  // Stall counter: counts held memory cycles and clears on any state change.
  always_comb begin
    if (mem_wait && !to_hit) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    else                     cnt_d = '0;
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state   = state_q;
  assign active  = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC1) || (state_q == S_EXEC2);
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl.
// Two configurations run side by side on the same stimulus:
//   inst0: no timeout, halt on illegal.
//   inst1: TIMEOUT_CYCLES=4, illegal executes as a NOP.
// The driver pushes expected outputs from an instruction-level model.
// The monitor pops them and compares on the falling edge.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] regdst;
    logic       regwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsource;
    logic       memread;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic [1:0] aluop;
    logic       alusrc;
    logic       active;
    logic       illegal;
    logic       timeout;
  } outs_t;

  // Instruction classes and phases of the reference model.
  localparam int C_ALU = 0, C_JR = 1, C_ADDIU = 2, C_LW = 3, C_SW = 4;
  localparam int C_BEQ = 5, C_BNE = 6, C_J = 7, C_JAL = 8, C_ILL = 9;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2;
  localparam int P_EX1 = 3, P_EX2 = 4, P_HALT = 7;

  int P_TO   [2] = '{0, 4};
  int P_HALT_ILL [2] = '{1, 0};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] fncode = '0;
  logic       waitrequest = 1'b0;
  logic       alu_zero = 1'b0;
  logic       jr_target_zero = 1'b0;

  logic [2:0] st_w [2];
  logic [1:0] regdst_w [2];
  logic [1:0] pcsource_w [2];
  logic [1:0] memtoreg_w [2];
  logic [1:0] aluop_w [2];
  logic       regwrite_w [2];
  logic       iord_w [2];
  logic       irwrite_w [2];
  logic       pcwrite_w [2];
  logic       memread_w [2];
  logic       memwrite_w [2];
  logic       alusrc_w [2];
  logic       active_w [2];
  logic       illegal_w [2];
  logic       timeout_w [2];

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(0), .TIMEOUT_W(8), .HALT_ON_ILLEGAL(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .fncode(fncode),
    .waitrequest(waitrequest), .alu_zero(alu_zero), .jr_target_zero(jr_target_zero),
    .state(st_w[0]), .regdst(regdst_w[0]), .regwrite(regwrite_w[0]), .iord(iord_w[0]),
    .irwrite(irwrite_w[0]), .pcwrite(pcwrite_w[0]), .pcsource(pcsource_w[0]),
    .memread(memread_w[0]), .memwrite(memwrite_w[0]), .memtoreg(memtoreg_w[0]),
    .aluop(aluop_w[0]), .alusrc(alusrc_w[0]), .active(active_w[0]),
    .illegal(illegal_w[0]), .timeout(timeout_w[0]));

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8), .HALT_ON_ILLEGAL(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .fncode(fncode),
    .waitrequest(waitrequest), .alu_zero(alu_zero), .jr_target_zero(jr_target_zero),
    .state(st_w[1]), .regdst(regdst_w[1]), .regwrite(regwrite_w[1]), .iord(iord_w[1]),
    .irwrite(irwrite_w[1]), .pcwrite(pcwrite_w[1]), .pcsource(pcsource_w[1]),
    .memread(memread_w[1]), .memwrite(memwrite_w[1]), .memtoreg(memtoreg_w[1]),
    .aluop(aluop_w[1]), .alusrc(alusrc_w[1]), .active(active_w[1]),
    .illegal(illegal_w[1]), .timeout(timeout_w[1]));

  always #5 clk = ~clk;

  outs_t exp_q [2][$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;

  // Reference model state, one per configuration.
  int m_ph  [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  bit m_ill [2] = '{0, 0};
  bit m_to  [2] = '{0, 0};

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return C_JR;
        if (fn inside {6'h21, 6'h23, 6'h24, 6'h25}) return C_ALU;
        return C_ILL;
      end
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h04: return C_BEQ;
      6'h05: return C_BNE;
      6'h09: return C_ADDIU;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      default: return C_ILL;
    endcase
  endfunction

  // What the controller should show during a cycle in phase ph.
  function automatic outs_t model_out(input int k, input int cls, input bit az);
    outs_t o;
    o = '0;
    o.st      = 3'(m_ph[k]);
    o.active  = (m_ph[k] >= P_FETCH) && (m_ph[k] <= P_EX2);
    o.illegal = m_ill[k];
    o.timeout = m_to[k];
    if (m_ph[k] == P_FETCH) o.memread = 1'b1;
    if (m_ph[k] == P_DECODE) begin o.irwrite = 1'b1; o.pcwrite = 1'b1; end
    if (m_ph[k] == P_EX1) begin
      case (cls)
        C_ALU:   o.aluop = 2'd2;
        C_JR:    begin o.pcwrite = 1'b1; o.pcsource = 2'd3; end
        C_ADDIU, C_SW: o.alusrc = 1'b1;
        C_LW:    begin o.alusrc = 1'b1; o.iord = 1'b1; o.memread = 1'b1; end
        C_BEQ:   begin o.aluop = 2'd1; o.pcsource = 2'd1; o.pcwrite = az; end
        C_BNE:   begin o.aluop = 2'd1; o.pcsource = 2'd1; o.pcwrite = !az; end
        C_J:     begin o.pcwrite = 1'b1; o.pcsource = 2'd2; end
        C_JAL:   begin
          o.pcwrite = 1'b1; o.pcsource = 2'd2; o.regwrite = 1'b1;
          o.regdst = 2'd2; o.memtoreg = 2'd2;
        end
        default: ;
      endcase
    end
    if (m_ph[k] == P_EX2) begin
      case (cls)
        C_ALU:   begin o.regwrite = 1'b1; o.regdst = 2'd1; end
        C_ADDIU: o.regwrite = 1'b1;
        C_LW:    begin o.regwrite = 1'b1; o.memtoreg = 2'd1; end
        C_SW:    begin o.iord = 1'b1; o.memwrite = 1'b1; o.alusrc = 1'b1; end
        default: ;
      endcase
    end
    return o;
  endfunction

  // Advance the model by one clock edge.
  task automatic advance(input int k, input int cls, input bit wr, input bit jz);
    int ph;
    bit held;
    ph = m_ph[k];
    held = wr && ((ph == P_FETCH) || (ph == P_EX1 && cls == C_LW) ||
                  (ph == P_EX2 && cls == C_SW));
    if (held) begin
      if (P_TO[k] > 0 && m_cnt[k] == P_TO[k] - 1) begin
        m_ph[k] = P_HALT; m_to[k] = 1'b1; m_cnt[k] = 0;
      end else if (m_cnt[k] < 255) begin
        m_cnt[k]++;
      end
      return;
    end
    m_cnt[k] = 0;
    case (ph)
      P_IDLE:   m_ph[k] = P_FETCH;
      P_FETCH:  m_ph[k] = P_DECODE;
      P_DECODE: m_ph[k] = P_EX1;
      P_EX1: begin
        if (cls inside {C_ALU, C_ADDIU, C_LW, C_SW}) m_ph[k] = P_EX2;
        else if (cls == C_JR) m_ph[k] = jz ? P_HALT : P_FETCH;
        else if (cls == C_ILL && P_HALT_ILL[k] != 0) begin
          m_ph[k] = P_HALT; m_ill[k] = 1'b1;
        end else m_ph[k] = P_FETCH;
      end
      P_EX2:    m_ph[k] = P_FETCH;
      default:  m_ph[k] = P_HALT;
    endcase
  endtask

  // One clock of stimulus: drive, record the expectation, step the model.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input bit wr,
                      input bit az, input bit jz, input bit rst);
    int cls;
    @(posedge clk);
    #1;
    opcode = op; fncode = fn; waitrequest = wr; alu_zero = az;
    jr_target_zero = jz; reset_n = !rst;
    cyc++;
    cls = classify(op, fn);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ph[k] = P_IDLE; m_cnt[k] = 0; m_ill[k] = 1'b0; m_to[k] = 1'b0;
        exp_q[k].push_back(model_out(k, cls, az));
      end else begin
        exp_q[k].push_back(model_out(k, cls, az));
        advance(k, cls, wr, jz);
      end
    end
  endtask

  // Run one instruction on inst0's timeline, inserting memory waits.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input bit az,
                       input bit jz, input int nwait);
    int w;
    bit wr;
    w = nwait;
    for (int c = 0; c < 20; c++) begin
      wr = 1'b0;
      if (w > 0 && ((m_ph[0] == P_EX1 && op == 6'h23) || (m_ph[0] == P_EX2 && op == 6'h2b))) begin
        wr = 1'b1; w--;
      end
      step(op, fn, wr, az, jz, 1'b0);
      if (m_ph[0] == P_FETCH || m_ph[0] == P_HALT) break;
    end
  endtask

  function automatic outs_t actual(input int k);
    outs_t a;
    a.st = st_w[k]; a.regdst = regdst_w[k]; a.regwrite = regwrite_w[k];
    a.iord = iord_w[k]; a.irwrite = irwrite_w[k]; a.pcwrite = pcwrite_w[k];
    a.pcsource = pcsource_w[k]; a.memread = memread_w[k]; a.memwrite = memwrite_w[k];
    a.memtoreg = memtoreg_w[k]; a.aluop = aluop_w[k]; a.alusrc = alusrc_w[k];
    a.active = active_w[k]; a.illegal = illegal_w[k]; a.timeout = timeout_w[k];
    return a;
  endfunction

  // Monitor: compare whatever expectation is pending for each instance.
  initial begin
    outs_t e, a;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          a = actual(k);
          n_chk++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL ctrl inst%0d cyc%0d got st=%0d bits=%h want st=%0d bits=%h",
                     k, cyc, a.st, a, e.st, e);
          end
        end
      end
    end
  end

  logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h09, 6'h23, 6'h2b, 6'h3f};
  logic [5:0] fns [7]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h08, 6'h00, 6'h2a};

  initial begin
    logic [5:0] cur_op, cur_fn;
    bit rst;
    // Reset and the directed instruction sequence.
    step(6'h00, 6'h21, 1'b0, 1'b0, 1'b0, 1'b1);
    step(6'h00, 6'h21, 1'b0, 1'b0, 1'b0, 1'b1);
    step(6'h00, 6'h21, 1'b0, 1'b0, 1'b0, 1'b0);          // IDLE -> FETCH
    instr(6'h00, 6'h21, 1'b0, 1'b0, 0);                   // addu
    instr(6'h23, 6'h00, 1'b0, 1'b0, 3);                   // lw, 3 waits
    instr(6'h2b, 6'h00, 1'b0, 1'b0, 2);                   // sw, 2 waits
    instr(6'h09, 6'h00, 1'b0, 1'b0, 0);                   // addiu
    instr(6'h04, 6'h00, 1'b0, 1'b0, 0);                   // beq not taken
    instr(6'h05, 6'h00, 1'b0, 1'b0, 0);                   // bne taken
    instr(6'h03, 6'h00, 1'b0, 1'b0, 0);                   // jal
    instr(6'h02, 6'h00, 1'b0, 1'b0, 0);                   // j
    instr(6'h00, 6'h08, 1'b0, 1'b1, 0);                   // jr to zero -> halt
    step(6'h00, 6'h08, 1'b0, 1'b0, 1'b0, 1'b0);           // sits halted
    step(6'h00, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    // Illegal opcode: inst0 halts, inst1 carries on.
    step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    instr(6'h3f, 6'h00, 1'b0, 1'b0, 0);
    step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // Fetch stall: inst1 times out after four held cycles, then reset mid-stall.
    step(6'h00, 6'h21, 1'b0, 1'b0, 1'b0, 1'b1);
    step(6'h00, 6'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(6'h00, 6'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    step(6'h00, 6'h21, 1'b1, 1'b0, 1'b0, 1'b1);
    step(6'h00, 6'h21, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised traffic; opcode only changes outside EXEC1/EXEC2.
    cur_op = 6'h00; cur_fn = 6'h21;
    for (int i = 0; i < 3000; i++) begin
      rst = (m_ph[0] == P_HALT) || (m_ph[1] == P_HALT) || ($urandom_range(0, 299) == 0);
      if (!(m_ph[0] inside {P_EX1, P_EX2}) && !(m_ph[1] inside {P_EX1, P_EX2})) begin
        cur_op = ops[$urandom_range(0, 9)];
        cur_fn = fns[$urandom_range(0, 6)];
      end
      step(cur_op, cur_fn, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, rst);
    end

    repeat (2) @(posedge clk);
    n_chk++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q[0].size() + exp_q[1].size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
